// File: rtl/div_seq.sv
// Multi-cycle restoring divider (signed/unsigned) with a FREE/BY_ZERO/ON/END handshake FSM.
// Produces {remainder, quotient} after DW shift-subtract iterations; annul_i flushes the in-flight operation.
module div_seq #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            signed_reg, signed_next;
  logic            sign1_reg, sign1_next;
  logic            sign2_reg, sign2_next;
  logic [DW-1:0]   dvs_reg, dvs_next;
  logic [DW-1:0]   rem_reg, rem_next;
  logic [DW-1:0]   quo_reg, quo_next;
  logic [2*DW-1:0] result_reg, result_next;
  logic            ready_reg, ready_next;

  logic [DW:0]     shifted;
  logic [DW:0]     trial;
  logic [DW-1:0]   mag1;
  logic [DW-1:0]   mag2;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;

  always_comb begin
    // Datapath helpers, evaluated unconditionally.
    shifted = {rem_reg, quo_reg[DW-1]};
    trial   = shifted - {1'b0, dvs_reg};
    mag1    = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
    mag2    = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
    quo_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quo_reg : quo_reg;
    rem_fix = (signed_reg && sign1_reg) ? -rem_reg : rem_reg;

    state_next  = state_reg;
    cnt_next    = cnt_reg;
    signed_next = signed_reg;
    sign1_next  = sign1_reg;
    sign2_next  = sign2_reg;
    dvs_next    = dvs_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    case (state_reg)
      FREE: begin
        result_next = '0;
        ready_next  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = BY_ZERO;
          end else begin
            state_next  = ON;
            signed_next = signed_div_i;
            sign1_next  = opdata1_i[DW-1];
            sign2_next  = opdata2_i[DW-1];
            dvs_next    = mag2;
            rem_next    = '0;
            quo_next    = mag1;
            cnt_next    = '0;
          end
        end
      end
      BY_ZERO: begin
        result_next = '0;
        if (annul_i) begin
          state_next = FREE;
          ready_next = 1'b0;
        end else begin
          state_next = END;
          ready_next = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_next  = FREE;
          cnt_next    = '0;
          result_next = '0;
          ready_next  = 1'b0;
        end else if (cnt_reg == CW'(DW)) begin
          state_next  = END;
          result_next = {rem_fix, quo_fix};
          ready_next  = 1'b1;
        end else begin
          // Quotient bits shift in at the bottom while dividend bits leave at the top.
          if (!trial[DW]) begin
            rem_next = trial[DW-1:0];
            quo_next = {quo_reg[DW-2:0], 1'b1};
          end else begin
            rem_next = shifted[DW-1:0];
            quo_next = {quo_reg[DW-2:0], 1'b0};
          end
          cnt_next = cnt_reg + CW'(1);
        end
      end
      END: begin
        if (!start_i) begin
          state_next  = FREE;
          result_next = '0;
          ready_next  = 1'b0;
        end
      end
      default: begin
        state_next  = FREE;
        result_next = '0;
        ready_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FREE;
      cnt_reg    <= '0;
      signed_reg <= 1'b0;
      sign1_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      signed_reg <= signed_next;
      sign1_reg  <= sign1_next;
      sign2_reg  <= sign2_next;
      dvs_reg    <= dvs_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (DW=32): latency, signed/unsigned results,
// divide-by-zero, handshake hold/clear, annul and mid-operation reset.
module tb_div_seq;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            signed_div;
  logic [DW-1:0]   opdata1;
  logic [DW-1:0]   opdata2;
  logic            start;
  logic            annul;
  logic [2*DW-1:0] result;
  logic            ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_seq #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, check latency (edges after the acceptance edge), result, hold and clear.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
    int k;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    // Scramble operands after acceptance; the latched copies must be used.
    opdata1    = ~a;
    opdata2    = b ^ 32'h5;
    signed_div = ~sgn;
    k = 0;
    while (!ready && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_result"}, result, exp);
    tick();
    tick();
    check({tag, "_hold_ready"}, 64'(ready), 64'd1);
    check({tag, "_hold_result"}, result, exp);
    start = 1'b0;
    tick();
    check({tag, "_clr_ready"}, 64'(ready), 64'd0);
    check({tag, "_clr_result"}, result, 64'd0);
  endtask

  // Watch ready for a window where no result may appear.
  task automatic expect_silent(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ready) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u7div2", 1'b0, 32'd7, 32'd2, 33, 64'h00000001_00000003);
    run_div("s_m7div2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s7div_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    run_div("divzero", 1'b0, 32'h12345678, 32'h0, 1, 64'h0);
    run_div("s_minint_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    run_div("u_max_div1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 33, 64'h00000000_FFFFFFFF);
    run_div("u_minint_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000 ^ 64'h80000000_80000000);

    // Start together with annul must not be accepted.
    signed_div = 1'b0;
    opdata1    = 32'd9;
    opdata2    = 32'd3;
    start      = 1'b1;
    annul      = 1'b1;
    expect_silent("free_annul_blocks", 5);
    start = 1'b0;
    annul = 1'b0;
    tick();

    // Annul at iteration 10.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    expect_silent("annul_no_result", 40);

    // Reset in the middle of an ON sequence.
    opdata1 = 32'd12345;
    opdata2 = 32'd6;
    start   = 1'b1;
    tick();
    repeat (15) tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    expect_silent("rst_no_result", 40);

    run_div("u100div7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one parameter: DW, default 32, operand width in bits.
REQ-002 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).
REQ-003 Ports SHALL be as follows:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- signed_div_i  input  1  1 = signed division, 0 = unsigned.
- opdata1_i  input  DW  dividend.
- opdata2_i  input  DW  divisor.
- start_i  input  1  request; requester holds it high until it sees ready_o.
- annul_i  input  1  cancel the in-flight or requested division (pipeline flush).
- result_o  output  2*DW  {remainder, quotient}, written by the EX/WB path into HI/LO.
- ready_o  output  1  result valid.

Function
REQ-004 The block SHALL implement a 4-state FSM: FREE, BY_ZERO, ON, END.
REQ-005 FREE, start_i=1, annul_i=0, opdata2_i=0 -> BY_ZERO.
REQ-006 FREE, start_i=1, annul_i=0, opdata2_i!=0 -> ON; the same edge SHALL latch signed_div_i, sign bits of both operands, magnitude of dividend and divisor; iteration counter cnt=0.
REQ-007 FREE with start_i=0 or annul_i=1 SHALL remain FREE with no register change other than outputs held at 0.
REQ-008 Magnitude SHALL be the two's-complement negation when signed_div_i=1 and operand MSB=1, else the raw operand; -2^(DW-1) SHALL yield magnitude 2^(DW-1) as unsigned DW bits.
REQ-009 ON with cnt<DW SHALL perform one restoring shift-subtract step per cycle, MSB first: trial = partial remainder minus divisor magnitude in DW+1 bits; if nonnegative, keep trial and shift in quotient bit 1, else keep the remainder and shift in 0; cnt increments.
REQ-010 ON with cnt=DW SHALL apply sign correction, load result_o, set ready_o=1, and go to END.
- Quotient negated iff signed and dividend sign XOR divisor sign.
- Remainder negated iff signed and dividend sign = 1.
REQ-011 BY_ZERO SHALL, on the next edge, load result_o=0, set ready_o=1, and go to END.
REQ-012 END with start_i=1 SHALL hold result_o and ready_o; END with start_i=0 SHALL go to FREE with result_o=0 and ready_o=0 on that edge.
REQ-013 annul_i=1 in ON or BY_ZERO SHALL go to FREE on that edge with ready_o=0 and result_o=0; no result SHALL be produced.
REQ-014 start_i deassertion in ON or BY_ZERO SHALL be ignored; operand input changes after acceptance SHALL NOT affect the result.
REQ-015 Latency: start accepted at edge ending cycle T -> ready_o=1 from cycle T+DW+2 (34 for DW=32); divide-by-zero -> ready_o=1 from cycle T+2.
REQ-016 Signed -2^(DW-1) / -1 SHALL wrap: quotient 2^(DW-1) pattern, remainder 0; no overflow flag.
REQ-017 ready_o and result_o SHALL be registered outputs; no combinational path from inputs to outputs.

Reset
REQ-018 rst=1 at any edge, in any state including mid-ON, SHALL force FREE, cnt=0, ready_o=0, and result_o=0, overriding start_i and annul_i.
REQ-019 rst SHALL take priority over annul_i, and annul_i over start_i.

Verification
REQ-020 Unsigned 7/2, start held: ready_o rises exactly 34 cycles after acceptance; result_o=64'h00000001_00000003; ready_o holds until start_i drops, then the outputs clear next cycle.
REQ-021 Signed -7/2 (FFFFFFF9/00000002): result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/-2: result_o=64'h00000001_FFFFFFFD.
REQ-022 Divisor 0: BY_ZERO for one cycle, ready_o=1 two cycles after acceptance, result_o=0.
REQ-023 Signed 80000000/FFFFFFFF: result_o=64'h00000000_80000000; unsigned FFFFFFFF/00000001: result_o=64'h00000000_FFFFFFFF.
REQ-024 annul_i pulsed at iteration 10, then rst pulsed mid-ON on a second division: FREE next edge each time, ready_o never asserts, and a following 100/7 returns 64'h00000002_0000000E.
